// File: rtl/svl_pkg.sv
// Shared types, default widths and the saturation helper for the square voice datapath.
package svl_pkg;

  typedef logic signed [31:0] sample_t;

  localparam int AMP_SHIFT_DEF = 20;
  localparam int VOL_SHIFT_DEF = 20;
  localparam int N_FILT_DEF    = 8;

  // Clamp a wide signed value into the 32-bit sample range.
  function automatic sample_t sat32(input logic signed [63:0] v);
    if (v > 64'sh0000_0000_7FFF_FFFF) begin
      return 32'sh7FFF_FFFF;
    end else if (v < 64'shFFFF_FFFF_8000_0000) begin
      return 32'sh8000_0000;
    end else begin
      return sample_t'(v);
    end
  endfunction

endpackage

// File: rtl/iir_lp_stage.sv
// Single-pole IIR low-pass: y <= y + ((x - y) >>> SHIFT), 33-bit difference.
module iir_lp_stage
  import svl_pkg::*;
#(
  parameter int SHIFT = 1
) (
  input  logic    clk,
  input  logic    reset,
  input  sample_t x,
  output sample_t y
);

  sample_t            r_y;
  logic signed [32:0] w_diff;
  logic signed [32:0] w_step;
  logic signed [32:0] w_sum;

  always_comb begin
    w_diff = {x[31], x} - {r_y[31], r_y};
    w_step = w_diff >>> SHIFT;
    w_sum  = {r_y[31], r_y} + w_step;
  end

  // The sum always lies between x and y, so dropping the guard bit cannot wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_y <= '0;
    end else begin
      r_y <= sample_t'(w_sum);
    end
  end

  assign y = r_y;

endmodule

// File: rtl/square_voice_lowpass.sv
// Voice datapath: loadable square oscillator -> volume multiply -> bank of IIR low-passs.
// Define MULT_SATURATE_EN to clamp the multiplier output instead of wrapping it.
module square_voice_lowpass
  import svl_pkg::*;
#(
  parameter int AMP_SHIFT = AMP_SHIFT_DEF,
  parameter int VOL_SHIFT = VOL_SHIFT_DEF,
  parameter int N_FILT    = N_FILT_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [31:0] load_sample,
  input  logic [31:0] load_counter,
  input  logic [31:0] wave_length,
  input  logic [31:0] volume,
  input  logic        filter_en,
  input  logic [2:0]  cutoff,
  output logic [31:0] osc_sample,
  output logic [31:0] osc_counter,
  output logic [31:0] mixed,
  output logic [31:0] audio_out
);

  localparam sample_t AMP_NEG = sample_t'(-(64'sd1 <<< AMP_SHIFT));

  sample_t            r_osc_sample;
  logic [31:0]        r_osc_counter;
  sample_t            r_mixed;
  sample_t            r_audio;

  sample_t            w_base_sample;
  logic [31:0]        w_base_counter;
  logic [31:0]        w_half_raw;
  logic [31:0]        w_half;
  logic signed [63:0] w_prod;
  logic signed [63:0] w_shifted;
  sample_t            w_mixed_next;
  sample_t            w_y [N_FILT];

  // A loaded sample of zero would never toggle audibly, so it resumes at the low rail.
  always_comb begin
    if (load) begin
      w_base_sample  = (load_sample == 32'd0) ? AMP_NEG : sample_t'(load_sample);
      w_base_counter = load_counter;
    end else begin
      w_base_sample  = r_osc_sample;
      w_base_counter = r_osc_counter;
    end
    w_half_raw = wave_length >> 1;
    w_half     = (w_half_raw == 32'd0) ? 32'd1 : w_half_raw;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_osc_sample  <= AMP_NEG;
      r_osc_counter <= 32'd1;
    end else if (w_base_counter >= w_half) begin
      r_osc_sample  <= -w_base_sample;
      r_osc_counter <= 32'd1;
    end else begin
      r_osc_sample  <= w_base_sample;
      r_osc_counter <= w_base_counter + 32'd1;
    end
  end

  always_comb begin
    w_prod    = $signed({{32{r_osc_sample[31]}}, r_osc_sample}) * $signed({32'd0, volume});
    w_shifted = w_prod >>> VOL_SHIFT;
`ifdef MULT_SATURATE_EN
    w_mixed_next = sat32(w_shifted);
`else
    w_mixed_next = sample_t'(w_shifted);
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_mixed <= '0;
    end else begin
      r_mixed <= w_mixed_next;
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < N_FILT; gi++) begin : g_filt
      iir_lp_stage #(
        .SHIFT(gi + 1)
      ) u_stage (
        .clk  (clk),
        .reset(reset),
        .x    (r_mixed),
        .y    (w_y[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (reset) begin
      r_audio <= '0;
    end else begin
      r_audio <= filter_en ? w_y[cutoff] : r_mixed;
    end
  end

  assign osc_sample  = r_osc_sample;
  assign osc_counter = r_osc_counter;
  assign mixed       = r_mixed;
  assign audio_out   = r_audio;

endmodule

// File: tb/tb_square_voice_lowpass.sv
// Scoreboard bench for square_voice_lowpass: expectations queued with stimulus, popped per cycle.
module tb_square_voice_lowpass;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        load = 1'b0;
  logic [31:0] load_sample = '0;
  logic [31:0] load_counter = '0;
  logic [31:0] wave_length = 32'd8;
  logic [31:0] volume = 32'h0010_0000;
  logic        filter_en = 1'b0;
  logic [2:0]  cutoff = 3'd0;
  logic [31:0] osc_sample;
  logic [31:0] osc_counter;
  logic [31:0] mixed;
  logic [31:0] audio_out;

  localparam logic [31:0] P1M = 32'h0010_0000;
  localparam logic [31:0] N1M = 32'hFFF0_0000;

  int n_cmp = 0;
  int n_err = 0;
  logic [31:0] q_exp[$];

  square_voice_lowpass dut (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .load_sample (load_sample),
    .load_counter(load_counter),
    .wave_length (wave_length),
    .volume      (volume),
    .filter_en   (filter_en),
    .cutoff      (cutoff),
    .osc_sample  (osc_sample),
    .osc_counter (osc_counter),
    .mixed       (mixed),
    .audio_out   (audio_out)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    load  = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  function automatic logic [31:0] osc_ref(input int n);
    return (((n / 4) % 2) == 0) ? N1M : P1M;
  endfunction

  task automatic test_reset();
    logic [31:0] e;
    do_reset();
    q_exp.push_back(N1M);
    q_exp.push_back(32'd1);
    q_exp.push_back(32'd0);
    q_exp.push_back(32'd0);
    e = q_exp.pop_front(); n_cmp++;
    if (osc_sample !== e) begin n_err++; $display("FAIL reset osc_sample: got %h expected %h", osc_sample, e); end
    e = q_exp.pop_front(); n_cmp++;
    if (osc_counter !== e) begin n_err++; $display("FAIL reset osc_counter: got %h expected %h", osc_counter, e); end
    e = q_exp.pop_front(); n_cmp++;
    if (mixed !== e) begin n_err++; $display("FAIL reset mixed: got %h expected %h", mixed, e); end
    e = q_exp.pop_front(); n_cmp++;
    if (audio_out !== e) begin n_err++; $display("FAIL reset audio_out: got %h expected %h", audio_out, e); end
  endtask

  task automatic test_square();
    logic [31:0] e;
    wave_length = 32'd8; volume = P1M; filter_en = 1'b0;
    do_reset();
    for (int n = 1; n <= 16; n++) begin
      q_exp.push_back(osc_ref(n));
      q_exp.push_back(32'(n % 4 + 1));
      q_exp.push_back(osc_ref(n - 1));
      q_exp.push_back((n >= 2) ? osc_ref(n - 2) : 32'd0);
    end
    for (int n = 1; n <= 16; n++) begin
      step();
      e = q_exp.pop_front(); n_cmp++;
      if (osc_sample !== e) begin n_err++; $display("FAIL square osc_sample step %0d: got %h expected %h", n, osc_sample, e); end
      e = q_exp.pop_front(); n_cmp++;
      if (osc_counter !== e) begin n_err++; $display("FAIL square osc_counter step %0d: got %h expected %h", n, osc_counter, e); end
      e = q_exp.pop_front(); n_cmp++;
      if (mixed !== e) begin n_err++; $display("FAIL square mixed step %0d: got %h expected %h", n, mixed, e); end
      e = q_exp.pop_front(); n_cmp++;
      if (audio_out !== e) begin n_err++; $display("FAIL square audio_out step %0d: got %h expected %h", n, audio_out, e); end
    end
  endtask

  task automatic test_volume();
    logic [31:0] e;
    wave_length = 32'd8; volume = 32'h0008_0000; filter_en = 1'b0;
    do_reset();
    for (int n = 1; n <= 12; n++)
      q_exp.push_back((n >= 9) ? 32'd0 : ((osc_ref(n - 1) == P1M) ? 32'd524288 : 32'hFFF8_0000));
    for (int n = 1; n <= 12; n++) begin
      if (n == 9) volume = 32'd0;
      step();
      e = q_exp.pop_front(); n_cmp++;
      if (mixed !== e) begin n_err++; $display("FAIL volume mixed step %0d: got %h expected %h", n, mixed, e); end
    end
  endtask

  // Steady +1M on mixed from a zeroed filter bank; returns after the input is settled.
  task automatic filter_prime(input logic [2:0] cut);
    wave_length = 32'hFFFF_FFFF; volume = 32'd0; filter_en = 1'b1; cutoff = cut;
    do_reset();
    load = 1'b1; load_sample = P1M; load_counter = 32'd1;
    step();
    load = 1'b0; volume = P1M;
    step();
  endtask

  task automatic test_filter_step();
    logic [31:0] e;
    filter_prime(3'd0);
    q_exp.push_back(32'd0);
    q_exp.push_back(32'd524288);
    q_exp.push_back(32'd786432);
    q_exp.push_back(32'd917504);
    q_exp.push_back(32'd983040);
    for (int n = 3; n <= 7; n++) begin
      step();
      e = q_exp.pop_front(); n_cmp++;
      if (audio_out !== e) begin n_err++; $display("FAIL filter_c0 audio_out step %0d: got %0d expected %0d", n, audio_out, e); end
    end
  endtask

  task automatic test_filter_switch();
    logic [31:0] e;
    filter_prime(3'd7);
    q_exp.push_back(32'd0);
    q_exp.push_back(32'd4096);
    q_exp.push_back(32'd8176);
    q_exp.push_back(32'd12240);
    q_exp.push_back(P1M);
    q_exp.push_back(32'd20320);
    for (int n = 3; n <= 8; n++) begin
      filter_en = (n != 7);
      step();
      e = q_exp.pop_front(); n_cmp++;
      if (audio_out !== e) begin n_err++; $display("FAIL filter_c7 audio_out step %0d: got %0d expected %0d", n, audio_out, e); end
    end
  endtask

  task automatic test_load();
    logic [31:0] e;
    logic [31:0] ls [4] = '{P1M, 32'd0, 32'd0, P1M};
    logic [31:0] lc [4] = '{32'd4, 32'd1, 32'd4, 32'h10};
    logic [31:0] wl [4] = '{32'd0, 32'd0, 32'd1, 32'd1};
    wave_length = 32'd8; volume = P1M; filter_en = 1'b0;
    do_reset();
    q_exp.push_back(N1M); q_exp.push_back(32'd1);
    q_exp.push_back(N1M); q_exp.push_back(32'd2);
    q_exp.push_back(P1M); q_exp.push_back(32'd1);
    q_exp.push_back(N1M); q_exp.push_back(32'd1);
    for (int i = 0; i < 4; i++) begin
      q_exp.push_back((i % 2 == 0) ? P1M : N1M);
      q_exp.push_back(32'd1);
    end
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin
        load = 1'b1; load_sample = ls[i]; load_counter = lc[i];
      end else begin
        load = 1'b0; wave_length = wl[i - 4];
      end
      step();
      e = q_exp.pop_front(); n_cmp++;
      if (osc_sample !== e) begin n_err++; $display("FAIL load osc_sample %0d: got %h expected %h", i, osc_sample, e); end
      e = q_exp.pop_front(); n_cmp++;
      if (osc_counter !== e) begin n_err++; $display("FAIL load osc_counter %0d: got %h expected %h", i, osc_counter, e); end
    end
    load = 1'b0;
  endtask

  task automatic test_volume_max();
    logic [31:0] e;
    wave_length = 32'hFFFF_FFFF; volume = 32'hFFFF_FFFF; filter_en = 1'b0;
    do_reset();
    load = 1'b1; load_sample = P1M; load_counter = 32'd1;
    step();
    load = 1'b0;
`ifdef MULT_SATURATE_EN
    q_exp.push_back(32'h7FFF_FFFF);
    q_exp.push_back(32'h8000_0000);
`else
    q_exp.push_back(32'hFFFF_FFFF);
    q_exp.push_back(32'h0000_0001);
`endif
    step();
    e = q_exp.pop_front(); n_cmp++;
    if (mixed !== e) begin n_err++; $display("FAIL volmax_pos mixed: got %h expected %h", mixed, e); end
    load = 1'b1; load_sample = N1M; load_counter = 32'd1;
    step();
    load = 1'b0;
    step();
    e = q_exp.pop_front(); n_cmp++;
    if (mixed !== e) begin n_err++; $display("FAIL volmax_neg mixed: got %h expected %h", mixed, e); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] e;
    wave_length = 32'd8; volume = P1M; filter_en = 1'b1; cutoff = 3'd0;
    do_reset();
    for (int n = 0; n < 6; n++) step();
    reset = 1'b1; load = 1'b1; load_sample = P1M; load_counter = 32'd3;
    q_exp.push_back(N1M);
    q_exp.push_back(32'd1);
    q_exp.push_back(32'd0);
    q_exp.push_back(32'd0);
    step();
    e = q_exp.pop_front(); n_cmp++;
    if (osc_sample !== e) begin n_err++; $display("FAIL midreset osc_sample: got %h expected %h", osc_sample, e); end
    e = q_exp.pop_front(); n_cmp++;
    if (osc_counter !== e) begin n_err++; $display("FAIL midreset osc_counter: got %h expected %h", osc_counter, e); end
    e = q_exp.pop_front(); n_cmp++;
    if (mixed !== e) begin n_err++; $display("FAIL midreset mixed: got %h expected %h", mixed, e); end
    e = q_exp.pop_front(); n_cmp++;
    if (audio_out !== e) begin n_err++; $display("FAIL midreset audio_out: got %h expected %h", audio_out, e); end
    reset = 1'b0; load = 1'b0;
  endtask

  initial begin
    test_reset();
    test_square();
    test_volume();
    test_filter_step();
    test_filter_switch();
    test_load();
    test_volume_max();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
